// File: rtl/configure.sv
// rtl/configure.sv - build-time defaults for the memory responder
package configure;

  localparam int          mem_depth   = 12;
  localparam logic [31:0] mem_base    = 32'h0000_0000;
  localparam int          wait_cycles = 2;

endpackage

// File: rtl/wires.sv
// rtl/wires.sv - memory request/response bus types
package wires;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

// File: rtl/mem_responder_ram.sv
// rtl/mem_responder_ram.sv - single-port synchronous-read word RAM with byte enables
module mem_responder_ram #(
  parameter int depth = 12
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [depth-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [2**depth];
  logic [31:0] rdata_q;

  // One access per cycle: either a byte-masked write or a registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side responder with wait states and a one-entry skid buffer
module mem_responder
  import wires::*;
#(
  parameter int          mem_depth   = configure::mem_depth,
  parameter logic [31:0] mem_base    = configure::mem_base,
  parameter int          wait_cycles = configure::wait_cycles
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  mem_in,
  output mem_out_type mem_out,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        fence;
    logic        en;
  } req_t;

  localparam logic [3:0] WAIT_INIT = 4'(wait_cycles);

  function automatic logic in_range(input req_t r);
    logic [31:0] off;
    off = r.addr - mem_base;
    return (off >> (mem_depth + 2)) == 32'd0;
  endfunction

  function automatic logic is_write(input req_t r);
    return !r.fence && (r.wstrb != 4'd0);
  endfunction

  function automatic logic is_read(input req_t r);
    return !r.fence && (r.wstrb == 4'd0);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        act_q, act_d;
  req_t        skid_q, skid_d;
  logic        ovf_q, ovf_d;
  logic        start;
  req_t        new_req;
  logic [31:0] act_d_off;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        unused_dbg;

  assign new_req = '{addr:  mem_in.mem_addr,
                     wdata: mem_in.mem_wdata,
                     wstrb: mem_in.mem_wstrb,
                     fence: mem_in.mem_fence,
                     en:    1'b1};

  // Next-state: accept into the active slot when free, else the skid slot, else drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    skid_d  = skid_q;
    ovf_d   = ovf_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_in.mem_valid) begin
          act_d = new_req;
          start = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
        if (mem_in.mem_valid) begin
          if (skid_q.en) begin
            ovf_d = 1'b1;
          end else begin
            skid_d = new_req;
          end
        end
      end
      RESP: begin
        if (skid_q.en) begin
          act_d  = skid_q;
          start  = 1'b1;
          skid_d = mem_in.mem_valid ? new_req : '0;
        end else if (mem_in.mem_valid) begin
          // Skid is empty, so the new request would be promoted straight away.
          act_d = new_req;
          start = 1'b1;
        end else begin
          act_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      if (WAIT_INIT == 4'd0) begin
        state_d = RESP;
        cnt_d   = 4'd0;
      end else begin
        state_d = WAIT;
        cnt_d   = WAIT_INIT;
      end
    end
  end

  // State, counter and request registers; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      act_q   <= '0;
      skid_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      skid_q  <= skid_d;
      ovf_q   <= ovf_d;
    end
  end

  // The array access for a request happens on the edge that enters RESP, so the
  // read word is registered during RESP and writes land before any later read.
  assign act_d_off = act_d.addr - mem_base;
  assign ram_en    = (state_d == RESP) && !rst && act_d.en && !act_d.fence && in_range(act_d);
  assign ram_we    = is_write(act_d);

  mem_responder_ram #(
    .depth (mem_depth)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (act_d.wstrb),
    .addr  (act_d_off[mem_depth+1:2]),
    .wdata (act_d.wdata),
    .rdata (ram_rdata)
  );

  // Response is a one-cycle pulse in RESP; only in-range reads return data.
  always_comb begin
    mem_out = '0;
    if (state_q == RESP) begin
      mem_out.mem_ready = 1'b1;
      if (is_read(act_q) && in_range(act_q)) begin
        mem_out.mem_rdata = ram_rdata;
      end
    end
  end

  assign overflow   = ovf_q;
  assign unused_dbg = ^{mem_in.mem_instr, act_d_off[1:0], act_d_off[31:mem_depth+2]};

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;
  import wires::*;

  logic        clk = 1'b0;
  logic        rst;
  mem_in_type  req, req0;
  mem_out_type rsp, rsp0;
  logic        ovf, ovf0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.mem_depth(12), .mem_base(32'h0), .wait_cycles(2)) dut (
    .clk(clk), .rst(rst), .mem_in(req), .mem_out(rsp), .overflow(ovf));

  mem_responder #(.mem_depth(12), .mem_base(32'h0), .wait_cycles(0)) dut0 (
    .clk(clk), .rst(rst), .mem_in(req0), .mem_out(rsp0), .overflow(ovf0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req  = '0;
    req0 = '0;
  endtask

  task automatic drive(input bit z, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic f);
    mem_in_type m;
    m.mem_valid = 1'b1;
    m.mem_fence = f;
    m.mem_instr = 1'b0;
    m.mem_addr  = a;
    m.mem_wdata = d;
    m.mem_wstrb = s;
    if (z) req0 = m;
    else   req  = m;
  endtask

  task automatic issue(input bit z, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic f);
    drive(z, a, d, s, f);
    step();
    idle();
  endtask

  // Returns cycles from request cycle to ready (1 = next cycle), -1 on timeout.
  task automatic wait_resp(input bit z, output int lat, output logic [31:0] data);
    logic r;
    lat = 1;
    r = z ? rsp0.mem_ready : rsp.mem_ready;
    while (!r && lat < 20) begin
      step();
      lat++;
      r = z ? rsp0.mem_ready : rsp.mem_ready;
    end
    if (!r) lat = -1;
    data = z ? rsp0.mem_rdata : rsp.mem_rdata;
  endtask

  task automatic poke(input bit z, input logic [31:0] a, input logic [31:0] d);
    int lat;
    logic [31:0] data;
    issue(z, a, d, 4'hF, 1'b0);
    wait_resp(z, lat, data);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #2;
    checks++; if (rsp !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", rsp); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (rsp0 !== '0) begin errors++; $display("FAIL reset_out0: got %h expected 0", rsp0); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] data;
    issue(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    wait_resp(0, lat, data);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_lat: got %0d expected 3", lat); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h expected 0", data); end
    step();
    issue(0, 32'h10, 32'h0, 4'h0, 1'b0);
    wait_resp(0, lat, data);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_lat: got %0d expected 3", lat); end
    checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", data); end
    step();
  endtask

  task automatic test_strobes();
    int lat;
    logic [31:0] data;
    poke(0, 32'h20, 32'h11223344);
    issue(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    wait_resp(0, lat, data);
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL strb_ack: got %h expected 0", data); end
    step();
    issue(0, 32'h20, 32'h0, 4'h0, 1'b0);
    wait_resp(0, lat, data);
    checks++; if (data !== 32'h11BB33DD) begin errors++; $display("FAIL strb_data: got %h expected 11bb33dd", data); end
    step();
  endtask

  task automatic test_skid_overflow();
    int cnt, at;
    logic [31:0] d2;
    poke(0, 32'h0, 32'hA0A0A0A0);
    poke(0, 32'h4, 32'hA4A4A4A4);
    poke(0, 32'h8, 32'hA8A8A8A8);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL skid_ovf_pre: got %b expected 0", ovf); end
    drive(0, 32'h0, 32'h0, 4'h0, 1'b0);
    step();
    drive(0, 32'h4, 32'h0, 4'h0, 1'b0);
    step();
    drive(0, 32'h8, 32'h0, 4'h0, 1'b0);
    step();
    idle();
    checks++; if (rsp.mem_ready !== 1'b1 || rsp.mem_rdata !== 32'hA0A0A0A0) begin
      errors++; $display("FAIL skid_first: got ready=%b data=%h expected 1 a0a0a0a0", rsp.mem_ready, rsp.mem_rdata); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL skid_ovf_set: got %b expected 1", ovf); end
    cnt = 0; at = 0; d2 = '0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (rsp.mem_ready) begin
        cnt++;
        if (cnt == 1) begin at = k; d2 = rsp.mem_rdata; end
      end
    end
    checks++; if (cnt !== 1) begin errors++; $display("FAIL skid_pulses: got %0d expected 1", cnt); end
    checks++; if (at !== 3) begin errors++; $display("FAIL skid_second_at: got %0d expected 3", at); end
    checks++; if (d2 !== 32'hA4A4A4A4) begin errors++; $display("FAIL skid_second_data: got %h expected a4a4a4a4", d2); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL skid_ovf_held: got %b expected 1", ovf); end
  endtask

  task automatic test_wait_zero();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) poke(1, 32'h60 + 4*i, 32'h10000000 + i * 32'h0101);
    for (int i = 0; i < 4; i++) begin
      exp = 32'h10000000 + i * 32'h0101;
      drive(1, 32'h60 + 4*i, 32'h0, 4'h0, 1'b0);
      step();
      idle();
      checks++; if (rsp0.mem_ready !== 1'b1 || rsp0.mem_rdata !== exp) begin
        errors++; $display("FAIL w0_resp%0d: got ready=%b data=%h expected 1 %h", i, rsp0.mem_ready, rsp0.mem_rdata, exp); end
      step();
      checks++; if (rsp0.mem_ready !== 1'b0) begin errors++; $display("FAIL w0_gap%0d: got ready=%b expected 0", i, rsp0.mem_ready); end
    end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL w0_ovf: got %b expected 0", ovf0); end
  endtask

  task automatic test_back_to_back();
    drive(1, 32'h70, 32'hCAFEF00D, 4'hF, 1'b0);
    step();
    drive(1, 32'h70, 32'h0, 4'h0, 1'b0);
    checks++; if (rsp0.mem_ready !== 1'b1 || rsp0.mem_rdata !== 32'h0) begin
      errors++; $display("FAIL raw_wack: got ready=%b data=%h expected 1 0", rsp0.mem_ready, rsp0.mem_rdata); end
    step();
    idle();
    checks++; if (rsp0.mem_ready !== 1'b1 || rsp0.mem_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL raw_read: got ready=%b data=%h expected 1 cafef00d", rsp0.mem_ready, rsp0.mem_rdata); end
    step();
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL raw_ovf: got %b expected 0", ovf0); end
  endtask

  task automatic test_fence_oor();
    int lat, cnt, at;
    logic [31:0] data, fd;
    drive(0, 32'h50, 32'h12345678, 4'hF, 1'b0);
    step();
    drive(0, 32'h50, 32'hFFFFFFFF, 4'hF, 1'b1);
    step();
    idle();
    step();
    checks++; if (rsp.mem_ready !== 1'b1 || rsp.mem_rdata !== 32'h0) begin
      errors++; $display("FAIL fence_wack: got ready=%b data=%h expected 1 0", rsp.mem_ready, rsp.mem_rdata); end
    cnt = 0; at = 0; fd = 32'hX;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (rsp.mem_ready) begin
        cnt++;
        if (cnt == 1) begin at = k; fd = rsp.mem_rdata; end
      end
    end
    checks++; if (cnt !== 1 || at !== 3) begin errors++; $display("FAIL fence_ack: got pulses=%0d at=%0d expected 1 at 3", cnt, at); end
    checks++; if (fd !== 32'h0) begin errors++; $display("FAIL fence_rdata: got %h expected 0", fd); end
    issue(0, 32'h50, 32'h0, 4'h0, 1'b0);
    wait_resp(0, lat, data);
    checks++; if (data !== 32'h12345678) begin errors++; $display("FAIL fence_nowrite: got %h expected 12345678", data); end
    step();
    issue(0, 32'h4000, 32'h0, 4'h0, 1'b0);
    wait_resp(0, lat, data);
    checks++; if (lat !== 3 || data !== 32'h0) begin errors++; $display("FAIL oor_read: got lat=%0d data=%h expected 3 0", lat, data); end
    cnt = 0;
    repeat (5) begin step(); if (rsp.mem_ready) cnt++; end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL oor_pulses: got %0d extra expected 0", cnt); end
  endtask

  task automatic test_reset_mid_wait();
    int lat, cnt;
    logic [31:0] data;
    poke(0, 32'h30, 32'h55AA55AA);
    issue(0, 32'h30, 32'hFFFFFFFF, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (rsp !== '0) begin errors++; $display("FAIL rst_out: got %h expected 0", rsp); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    step();
    step();
    rst = 1'b0;
    cnt = 0;
    repeat (6) begin step(); if (rsp.mem_ready) cnt++; end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL rst_noready: got %0d pulses expected 0", cnt); end
    issue(0, 32'h30, 32'h0, 4'h0, 1'b0);
    wait_resp(0, lat, data);
    checks++; if (lat !== 3 || data !== 32'h55AA55AA) begin errors++; $display("FAIL rst_prior: got lat=%0d data=%h expected 3 55aa55aa", lat, data); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_skid_overflow();
    test_wait_zero();
    test_back_to_back();
    test_fence_oor();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
